// File: rtl/bus_arb2_32_pkg.sv
// Shared types and encodings for the two-requester arbiter / output register.
// Imported by the grant logic and the top.
package bus_arb2_32_pkg;

    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic g0;
        logic g1;
    } grant_t;

    // Datapath select: s0 low passes requester 0, high passes requester 1.
    function automatic logic [31:0] mux2_32(
        input logic        s0,
        input logic [31:0] a,
        input logic [31:0] b
    );
        return s0 ? b : a;
    endfunction

endpackage

// File: rtl/bus_arb2_32_arb_rr2.sv
// Pure combinational two-way grant: round-robin on ties when fair,
// otherwise requester 0 always wins a tie.
module arb_rr2
    import bus_arb2_32_pkg::*;
(
    input  logic   i_v0,
    input  logic   i_v1,
    input  logic   i_last,
    input  logic   i_fair,
    output grant_t o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_v0 && i_v1) begin
            // i_last holds the source of the previous load; the other side wins the tie.
            if (i_fair && (i_last == SRC_REQ0)) begin
                o_grant.g1 = 1'b1;
            end else begin
                o_grant.g0 = 1'b1;
            end
        end else if (i_v0) begin
            o_grant.g0 = 1'b1;
        end else if (i_v1) begin
            o_grant.g1 = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arb2_32.sv
// Two-requester arbiter feeding a 1-entry valid/ready output register
// for one shared 32-bit path, with a wrapping transfer counter.
module bus_arb2_32
    import bus_arb2_32_pkg::*;
#(
    parameter int FAIR  = 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_req0_v,
    input  logic [31:0]      i_req0_d,
    output logic             o_req0_r,
    input  logic             i_req1_v,
    input  logic [31:0]      i_req1_d,
    output logic             o_req1_r,
    output logic             o_out_v,
    output logic [31:0]      o_out_d,
    output logic             o_out_src,
    input  logic             i_out_r,
    output logic [CNT_W-1:0] o_xfer_cnt
);

    localparam logic L_FAIR = (FAIR != 0);

    arb_state_e       r_state;
    logic [31:0]      r_out_d;
    logic             r_out_src;
    logic             r_last;
    logic [CNT_W-1:0] r_xfer_cnt;

    grant_t           w_grant;
    logic             w_load_ok;
    logic             w_load;
    logic [31:0]      w_mux_d;

    arb_rr2 u_arb (
        .i_v0    (i_req0_v),
        .i_v1    (i_req1_v),
        .i_last  (r_last),
        .i_fair  (L_FAIR),
        .o_grant (w_grant)
    );

    assign w_mux_d   = mux2_32(w_grant.g1, i_req0_d, i_req1_d);
    assign w_load_ok = (r_state == ST_EMPTY) || i_out_r;

    // Gating with i_clr keeps both accepts low while reset is held.
    assign o_req0_r = w_grant.g0 & w_load_ok & i_clr;
    assign o_req1_r = w_grant.g1 & w_load_ok & i_clr;
    assign w_load   = o_req0_r | o_req1_r;

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state    <= ST_EMPTY;
            r_out_d    <= '0;
            r_out_src  <= SRC_REQ0;
            r_last     <= SRC_REQ1;
            r_xfer_cnt <= '0;
        end else begin
            if (w_load) begin
                r_out_d    <= w_mux_d;
                r_out_src  <= w_grant.g1;
                r_last     <= w_grant.g1;
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A load in this state is a same-cycle drain and refill.
                    if (!w_load && i_out_r) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_out_v    = (r_state == ST_FULL);
    assign o_out_d    = r_out_d;
    assign o_out_src  = r_out_src;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_bus_arb2_32.sv
// Directed bench for bus_arb2_32: a fair 4-bit-counter instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_bus_arb2_32;

    logic        clk;
    logic        clr;
    logic        req0_v, req1_v, out_r;
    logic [31:0] req0_d, req1_d;

    logic        a_req0_r, a_req1_r, a_out_v, a_out_src;
    logic [31:0] a_out_d;
    logic [3:0]  a_cnt;

    logic        b_req0_r, b_req1_r, b_out_v, b_out_src;
    logic [31:0] b_out_d;
    logic [15:0] b_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    bus_arb2_32 #(.FAIR(1), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_clr(clr),
        .i_req0_v(req0_v), .i_req0_d(req0_d), .o_req0_r(a_req0_r),
        .i_req1_v(req1_v), .i_req1_d(req1_d), .o_req1_r(a_req1_r),
        .o_out_v(a_out_v), .o_out_d(a_out_d), .o_out_src(a_out_src),
        .i_out_r(out_r), .o_xfer_cnt(a_cnt)
    );

    bus_arb2_32 #(.FAIR(0), .CNT_W(16)) u_dut_fp (
        .i_clk(clk), .i_clr(clr),
        .i_req0_v(req0_v), .i_req0_d(req0_d), .o_req0_r(b_req0_r),
        .i_req1_v(req1_v), .i_req1_d(req1_d), .o_req1_r(b_req1_r),
        .o_out_v(b_out_v), .o_out_d(b_out_d), .o_out_src(b_out_src),
        .i_out_r(out_r), .o_xfer_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    logic [31:0] exp_src [4] = '{0, 1, 0, 1};

    initial begin
        clr    = 1'b0;
        req0_v = 1'b1;
        req1_v = 1'b1;
        req0_d = 32'h1111_1111;
        req1_d = 32'h2222_2222;
        out_r  = 1'b1;

        // 1: reset with both requesters valid
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_v", {31'd0, a_out_v}, 32'd0);
        chk("rst_req0_r", {31'd0, a_req0_r}, 32'd0);
        chk("rst_req1_r", {31'd0, a_req1_r}, 32'd0);
        chk("rst_cnt", {28'd0, a_cnt}, 32'd0);
        chk("rst_out_d", a_out_d, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        step();
        chk("first_out_v", {31'd0, a_out_v}, 32'd1);
        chk("first_out_d", a_out_d, 32'h1111_1111);
        chk("first_src", {31'd0, a_out_src}, 32'd0);

        // 2: round-robin vs fixed priority
        req0_d = 32'hA5A5_0000;
        req1_d = 32'h0000_5A5A;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_src", {31'd0, a_out_src}, exp_src[i]);
            chk("rr_out_d", a_out_d, (exp_src[i] == 0) ? 32'hA5A5_0000 : 32'h0000_5A5A);
            chk("fp_src", {31'd0, b_out_src}, 32'd0);
            chk("fp_out_d", b_out_d, 32'hA5A5_0000);
        end
        chk("rr_cnt", {28'd0, a_cnt}, 32'd4);
        chk("fp_cnt", {16'd0, b_cnt}, 32'd4);

        // 3: backpressure, then same-cycle drain and refill
        out_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_d = 32'h100 + i;
            req1_d = 32'h200 + i;
            #1;
            chk("bp_req0_r", {31'd0, a_req0_r}, 32'd0);
            chk("bp_req1_r", {31'd0, a_req1_r}, 32'd0);
            step();
            chk("bp_out_d", a_out_d, 32'h0000_5A5A);
            chk("bp_out_v", {31'd0, a_out_v}, 32'd1);
        end
        out_r  = 1'b1;
        req0_d = 32'hCAFE_0000;
        req1_d = 32'hBEEF_0000;
        #1;
        chk("refill_req0_r", {31'd0, a_req0_r}, 32'd1);
        step();
        chk("refill_out_d", a_out_d, 32'hCAFE_0000);
        chk("refill_out_v", {31'd0, a_out_v}, 32'd1);
        chk("refill_cnt", {28'd0, a_cnt}, 32'd5);

        // 4: single requester 1, then requester 0 joins
        req0_v = 1'b0;
        req1_d = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("solo_req1_r", {31'd0, a_req1_r}, 32'd1);
            step();
            chk("solo_out_d", a_out_d, 32'hFFFF_FFFF);
            chk("solo_src", {31'd0, a_out_src}, 32'd1);
        end
        req0_v = 1'b1;
        req0_d = 32'h0000_0123;
        #1;
        chk("join_req0_r", {31'd0, a_req0_r}, 32'd1);
        chk("join_req1_r", {31'd0, a_req1_r}, 32'd0);
        step();
        chk("join_src", {31'd0, a_out_src}, 32'd0);
        chk("join_cnt", {28'd0, a_cnt}, 32'd8);

        // 6: drain only, priority must survive idle cycles
        req0_v = 1'b0;
        req1_v = 1'b0;
        step();
        chk("drain_out_v", {31'd0, a_out_v}, 32'd0);
        chk("drain_out_d", a_out_d, 32'h0000_0123);
        chk("drain_cnt", {28'd0, a_cnt}, 32'd8);
        step();
        req0_v = 1'b1;
        req1_v = 1'b1;
        #1;
        chk("post_drain_req1_r", {31'd0, a_req1_r}, 32'd1);
        chk("post_drain_req0_r", {31'd0, a_req0_r}, 32'd0);
        step();
        chk("post_drain_src", {31'd0, a_out_src}, 32'd1);

        // 5: counter wrap, then async reset mid-cycle while full
        req1_v = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req0_d = 32'(i);
            step();
            if (i == 14) chk("wrap_cnt15", {28'd0, a_cnt}, 32'd15);
        end
        chk("wrap_cnt0", {28'd0, a_cnt}, 32'd0);
        chk("wrap_out_d", a_out_d, 32'd15);
        out_r = 1'b0;
        #3;
        clr = 1'b0;
        #1;
        chk("async_out_v", {31'd0, a_out_v}, 32'd0);
        chk("async_req0_r", {31'd0, a_req0_r}, 32'd0);
        chk("async_out_d", a_out_d, 32'd0);
        chk("async_fp_out_v", {31'd0, b_out_v}, 32'd0);
        @(negedge clk);
        clr = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
